// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared ALU. It grants one requester, drives the
// ALU from registered operands, waits the op latency, then returns the result on rsp.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready shows the combinational grant
// EXEC   | ALU driven from operand regs; counting hold cycles
// RESP   | result captured; waiting for the rsp_valid/rsp_ready handshake
module alu_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_op_a,
  input  logic [NUM_REQ*32-1:0] req_op_b,
  input  logic [NUM_REQ*5-1:0]  req_ctrl,
  output logic [31:0]           alu_operand_a,
  output logic [31:0]           alu_operand_b,
  output logic [4:0]            alu_control,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  busy
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, id_q, grant_idx, cand_idx;
  logic              grant_found;
  logic [31:0]       op_a_q, op_b_q;
  logic [4:0]        ctrl_q;
  logic [CNT_W-1:0]  cnt_q, cnt_last;
  logic              rsp_valid_q, rsp_zero_q;
  logic [31:0]       rsp_result_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic              accept, exec_done, rsp_fire;

  // Search starts one past the last grant, so back-to-back grants rotate.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign cnt_last  = (ctrl_q == 5'b00100 || ctrl_q == 5'b00101) ? CNT_W'(MULDIV_CYCLES - 1) : '0;
  assign accept    = (state_q == S_IDLE) && grant_found;
  assign exec_done = (state_q == S_EXEC) && (cnt_q == cnt_last);
  assign rsp_fire  = rsp_valid_q && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_found) state_d = S_EXEC;
      S_EXEC:  if (cnt_q == cnt_last) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
    busy = (state_q != S_IDLE);
  end

  // Operand regs change only on a grant, so the ALU never sees requester inputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      ctrl_q       <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      if (accept) begin
        op_a_q       <= req_op_a[32*grant_idx +: 32];
        op_b_q       <= req_op_b[32*grant_idx +: 32];
        ctrl_q       <= req_ctrl[5*grant_idx +: 5];
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
        cnt_q        <= '0;
      end else if (state_q == S_EXEC && !exec_done) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (exec_done) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
        rsp_id_q     <= id_q;
        rsp_valid_q  <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign alu_operand_a = op_a_q;
  assign alu_operand_b = op_b_q;
  assign alu_control   = ctrl_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_id        = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the ALU ports.
// Latency is counted in clock edges from the cycle in which req_ready is first seen.
module tb_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam logic [4:0] ADD = 5'b00001, SUB = 5'b00010, MUL = 5'b00100, DIV = 5'b00101;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_op_a, req_op_b;
  logic [NUM_REQ*5-1:0]  req_ctrl;
  logic [31:0]           alu_operand_a, alu_operand_b, alu_result;
  logic [4:0]            alu_control;
  logic                  alu_zero;
  logic                  rsp_valid, rsp_ready, rsp_zero, busy;
  logic [1:0]            rsp_id;
  logic [31:0]           rsp_result;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.NUM_REQ(4), .ID_W(2), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_ctrl(req_ctrl),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_control)
      ADD:     alu_result = alu_operand_a + alu_operand_b;
      SUB:     alu_result = alu_operand_a - alu_operand_b;
      MUL:     alu_result = alu_operand_a * alu_operand_b;
      DIV:     alu_result = (alu_operand_b == 32'd0) ? 32'hFFFF_FFFF : alu_operand_a / alu_operand_b;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] c);
    req_valid[i]        = v;
    req_op_a[32*i +: 32] = a;
    req_op_b[32*i +: 32] = b;
    req_ctrl[5*i +: 5]   = c;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {56'd0, req_ready, rsp_valid, rsp_id, rsp_zero, busy}, 64'd0);
    chk({tag, "_alu_a"}, {32'd0, alu_operand_a}, 64'd0);
    chk({tag, "_alu_b"}, {32'd0, alu_operand_b}, 64'd0);
    chk({tag, "_alu_c"}, {59'd0, alu_control}, 64'd0);
    chk({tag, "_rsp_res"}, {32'd0, rsp_result}, 64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits for a grant, accepts it, waits for the response and (if rsp_ready) consumes it.
  task automatic do_grant(input logic [3:0] drop, output int g, output int lat,
                          output logic [1:0] id, output logic [31:0] res, output logic z);
    int n;
    n = 0; g = -1; lat = 0; id = '0; res = '0; z = 1'b0;
    #1;
    while (req_ready == '0 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (req_ready == '0) begin
      chk("grant_timeout", 64'd1, 64'd0);
      return;
    end
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
    @(posedge clk); #1;
    lat = 1;
    if (drop[g]) req_valid[g] = 1'b0;
    while (!rsp_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'd1, 64'd0);
      return;
    end
    id = rsp_id; res = rsp_result; z = rsp_zero;
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  int g, lat;
  logic [1:0] id;
  logic [31:0] res;
  logic z, seen;
  int exp_seq [4] = '{1, 3, 1, 3};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op_a = '0; req_op_b = '0; req_ctrl = '0; rsp_ready = 1'b1;

    // 1: reset values, then a single ADD
    repeat (2) @(posedge clk);
    #1 check_zero("t1_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'd5, 32'd7, ADD);
    do_grant(4'b1111, g, lat, id, res, z);
    chk("t1_grant", 64'(g), 64'd0);
    chk("t1_latency", 64'(lat), 64'd2);
    chk("t1_id", {62'd0, id}, 64'd0);
    chk("t1_result", {32'd0, res}, 64'd12);
    chk("t1_zero", {63'd0, z}, 64'd0);
    chk("t1_idle_after", {62'd0, rsp_valid, busy}, 64'd0);

    // 2: four simultaneous SUBs from fresh priority
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'd3, 32'd3, SUB);
    for (int k = 0; k < NUM_REQ; k++) begin
      do_grant(4'b1111, g, lat, id, res, z);
      chk("t2_grant", 64'(g), 64'(k));
      chk("t2_id", {62'd0, id}, 64'(k));
      chk("t2_res_zero", {31'd0, res, z}, {31'd0, 32'd0, 1'b1});
    end

    // 3: MUL and divide-by-zero hold for four cycles
    set_req(0, 1'b1, 32'd6, 32'd7, MUL);
    do_grant(4'b1111, g, lat, id, res, z);
    chk("t3_mul_latency", 64'(lat), 64'd5);
    chk("t3_mul_result", {32'd0, res}, 64'd42);
    chk("t3_mul_zero", {63'd0, z}, 64'd0);
    set_req(0, 1'b1, 32'd10, 32'd0, DIV);
    do_grant(4'b1111, g, lat, id, res, z);
    chk("t3_div_latency", 64'(lat), 64'd5);
    chk("t3_div_result", {32'd0, res}, 64'h0000_0000_FFFF_FFFF);

    // 4: response back-pressure with req2 pending
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd2, ADD);
    do_grant(4'b1111, g, lat, id, res, z);
    set_req(2, 1'b1, 32'd4, 32'd4, ADD);
    repeat (10) begin
      @(posedge clk); #1;
      chk("t4_hold", {24'd0, rsp_valid, busy, req_ready, rsp_id, rsp_result},
          {24'd0, 1'b1, 1'b1, 4'b0000, 2'd0, 32'd3});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_back_idle", {58'd0, rsp_valid, busy, req_ready}, {58'd0, 1'b0, 1'b0, 4'b0100});
    do_grant(4'b1111, g, lat, id, res, z);
    chk("t4_req2_grant", 64'(g), 64'd2);
    chk("t4_req2_result", {30'd0, id, res}, {30'd0, 2'd2, 32'd8});

    // 5: fairness with req1/req3 always valid
    apply_reset();
    set_req(1, 1'b1, 32'd0, 32'd0, ADD);
    set_req(3, 1'b1, 32'd0, 32'd0, ADD);
    for (int k = 0; k < 4; k++) begin
      do_grant(4'b0001, g, lat, id, res, z);
      chk("t5_rotate", 64'(g), 64'(exp_seq[k]));
    end
    set_req(0, 1'b1, 32'd9, 32'd9, ADD);
    do_grant(4'b0001, g, lat, id, res, z);
    chk("t5_req0_grant", 64'(g), 64'd0);
    chk("t5_req0_result", {32'd0, res}, 64'd18);
    do_grant(4'b0001, g, lat, id, res, z);
    chk("t5_after_req0", 64'(g), 64'd1);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // 6: reset in the middle of a MUL
    set_req(2, 1'b1, 32'd6, 32'd7, MUL);
    #1;
    chk("t6_grant", {60'd0, req_ready}, 64'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    chk("t6_mid_exec", {26'd0, busy, alu_control, alu_operand_a}, {26'd0, 1'b1, MUL, 32'd6});
    rst_n = 1'b0;
    #1 check_zero("t6_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("t6_no_rsp", {63'd0, seen}, 64'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'd0, 32'd0, ADD);
    #1;
    chk("t6_priority", {60'd0, req_ready}, 64'b0001);
    req_valid = '0;
    #1;
    chk("t6_withdraw", {60'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    chk("t6_idle", {63'd0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
